// File: rtl/playback_status_counter.sv
// -----------------------------------------------------------------------------
// PlaybackStatusCounter
//
// Purpose:
//   Generates the BCD status digits that the display mux shows while a track
//   plays: elapsed play time as M:SS (0:00..9:59) and the volume level as two
//   BCD digits (00..VOL_MAX). Time advances once per second while playing.
//   Any single volume press switches the display to the volume for
//   SHOW_VOL_SECS seconds, after which it falls back to the play time.
//   Sits between the player control/debounce logic and the display mux.
//
// Parameters:
//   CLK_FREQ       clock cycles per second (prescaler terminal count + 1)
//   VOL_DEFAULT    volume after reset, decimal, must be <= VOL_MAX
//   VOL_MAX        volume saturation ceiling, decimal, must be <= 99
//   SHOW_VOL_SECS  how long the volume stays on the display after a press
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   play       in   level, 1 = time counts, 0 = paused (prescaler holds)
//   restart    in   1-cycle pulse, clears time and prescaler (track change)
//   vol_up     in   1-cycle pulse, debounced, volume +1
//   vol_down   in   1-cycle pulse, debounced, volume -1
//   volume0    out  volume units digit, BCD
//   volume1    out  volume tens digit, BCD
//   minutes0   out  minutes digit, BCD 0..9
//   seconds0   out  seconds units digit, BCD 0..9
//   seconds1   out  seconds tens digit, BCD 0..5
//   select     out  1 = display shows volume, 0 = display shows time
//   time_wrap  out  1-cycle pulse when the time rolls 9:59 -> 0:00
// -----------------------------------------------------------------------------
module playback_status_counter #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int VOL_DEFAULT   = 50,
  parameter int VOL_MAX       = 99,
  parameter int SHOW_VOL_SECS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       restart,
  input  logic       vol_up,
  input  logic       vol_down,
  output logic [3:0] volume0,
  output logic [3:0] volume1,
  output logic [3:0] minutes0,
  output logic [3:0] seconds0,
  output logic [3:0] seconds1,
  output logic       select,
  output logic       time_wrap
);

  localparam int PRE_W       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SHOW_CYCLES = SHOW_VOL_SECS * CLK_FREQ;
  localparam int TMR_W       = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);
  // Loading N-1 and leaving at 0 keeps the volume on screen for exactly N cycles.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);

  localparam logic [3:0] VOL_MAX_TENS  = 4'(VOL_MAX / 10);
  localparam logic [3:0] VOL_MAX_UNITS = 4'(VOL_MAX % 10);
  localparam logic [3:0] VOL_DEF_TENS  = 4'(VOL_DEFAULT / 10);
  localparam logic [3:0] VOL_DEF_UNITS = 4'(VOL_DEFAULT % 10);

  typedef enum logic {
    SHOW_TIME = 1'b0,
    SHOW_VOL  = 1'b1
  } selState_e;

  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [3:0]       sec0_q, sec0_d;
  logic [3:0]       sec1_q, sec1_d;
  logic [3:0]       min0_q, min0_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       volUnits_q, volUnits_d;
  logic [3:0]       volTens_q, volTens_d;
  logic [TMR_W-1:0] selTimer_q;
  selState_e        selState_q;

  logic tick;
  logic pressUp;
  logic pressDown;
  logic atMax;
  logic atMin;

  // One-second strobe; only meaningful while playing.
  assign tick = play && (prescaler_q == PRE_LAST);

  // Pressing both buttons together is treated as no press at all.
  assign pressUp   = vol_up & ~vol_down;
  assign pressDown = vol_down & ~vol_up;

  assign atMax = (volTens_q == VOL_MAX_TENS) && (volUnits_q == VOL_MAX_UNITS);
  assign atMin = (volTens_q == 4'd0) && (volUnits_q == 4'd0);

  // Play-time next state: restart beats a coincident tick, so a track change
  // never produces an increment or a wrap pulse. The BCD chain carries
  // s0 -> s1 -> m0 and the wrap pulse marks the 9:59 -> 0:00 rollover.
  always_comb begin
    prescaler_d = prescaler_q;
    sec0_d      = sec0_q;
    sec1_d      = sec1_q;
    min0_d      = min0_q;
    wrap_d      = 1'b0;
    if (restart) begin
      prescaler_d = '0;
      sec0_d      = 4'd0;
      sec1_d      = 4'd0;
      min0_d      = 4'd0;
    end else begin
      if (play) begin
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
      end
      if (tick) begin
        if (sec0_q != 4'd9) begin
          sec0_d = sec0_q + 4'd1;
        end else begin
          sec0_d = 4'd0;
          if (sec1_q != 4'd5) begin
            sec1_d = sec1_q + 4'd1;
          end else begin
            sec1_d = 4'd0;
            if (min0_q != 4'd9) begin
              min0_d = min0_q + 4'd1;
            end else begin
              min0_d = 4'd0;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
  end

  // Volume next state: two-digit BCD that saturates at 00 and VOL_MAX,
  // carrying 09 -> 10 on the way up and borrowing 10 -> 09 on the way down.
  always_comb begin
    volUnits_d = volUnits_q;
    volTens_d  = volTens_q;
    if (pressUp && !atMax) begin
      if (volUnits_q == 4'd9) begin
        volUnits_d = 4'd0;
        volTens_d  = volTens_q + 4'd1;
      end else begin
        volUnits_d = volUnits_q + 4'd1;
      end
    end else if (pressDown && !atMin) begin
      if (volUnits_q == 4'd0) begin
        volUnits_d = 4'd9;
        volTens_d  = volTens_q - 4'd1;
      end else begin
        volUnits_d = volUnits_q - 4'd1;
      end
    end
  end

  // Time and volume registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= '0;
      sec0_q      <= 4'd0;
      sec1_q      <= 4'd0;
      min0_q      <= 4'd0;
      wrap_q      <= 1'b0;
      volUnits_q  <= VOL_DEF_UNITS;
      volTens_q   <= VOL_DEF_TENS;
    end else begin
      prescaler_q <= prescaler_d;
      sec0_q      <= sec0_d;
      sec1_q      <= sec1_d;
      min0_q      <= min0_d;
      wrap_q      <= wrap_d;
      volUnits_q  <= volUnits_d;
      volTens_q   <= volTens_d;
    end
  end

  // Display-select FSM. Any valid press (even at a volume limit) enters or
  // re-enters SHOW_VOL with a fresh window; the timer then runs every clock
  // regardless of play and the FSM returns to SHOW_TIME when it hits zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      selState_q <= SHOW_TIME;
      selTimer_q <= '0;
    end else if (pressUp || pressDown) begin
      selState_q <= SHOW_VOL;
      selTimer_q <= TMR_LOAD;
    end else if (selState_q == SHOW_VOL) begin
      if (selTimer_q == '0) begin
        selState_q <= SHOW_TIME;
      end else begin
        selTimer_q <= selTimer_q - 1'b1;
      end
    end
  end

  assign volume0   = volUnits_q;
  assign volume1   = volTens_q;
  assign minutes0  = min0_q;
  assign seconds0  = sec0_q;
  assign seconds1  = sec1_q;
  assign select    = (selState_q == SHOW_VOL);
  assign time_wrap = wrap_q;

endmodule

// File: tb/tb_playback_status_counter.sv
// -----------------------------------------------------------------------------
// tb_playback_status_counter
//
// Drives the status counter with directed and randomized play/restart/volume
// activity and compares every output against a reference model that tracks
// play time as a plain seconds count, volume as an integer and the volume
// display window as a count of remaining cycles.
// -----------------------------------------------------------------------------
module tb_playback_status_counter;

  localparam int CLK_FREQ  = 10;
  localparam int SHOW_SECS = 2;
  localparam int WINDOW    = CLK_FREQ * SHOW_SECS;
  localparam int VOL_DEF   = 50;
  localparam int VOL_TOP   = 99;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic       restart = 1'b0;
  logic       volUp = 1'b0;
  logic       volDown = 1'b0;
  logic [3:0] volume0, volume1, minutes0, seconds0, seconds1;
  logic       select, timeWrap;

  int nChecks = 0;
  int nPassed = 0;

  // Reference model state.
  int mSecs = 0;
  int mPre = 0;
  int mVol = VOL_DEF;
  int mLeft = 0;
  bit mWrap = 1'b0;

  playback_status_counter #(
    .CLK_FREQ     (CLK_FREQ),
    .VOL_DEFAULT  (VOL_DEF),
    .VOL_MAX      (VOL_TOP),
    .SHOW_VOL_SECS(SHOW_SECS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .restart  (restart),
    .vol_up   (volUp),
    .vol_down (volDown),
    .volume0  (volume0),
    .volume1  (volume1),
    .minutes0 (minutes0),
    .seconds0 (seconds0),
    .seconds1 (seconds1),
    .select   (select),
    .time_wrap(timeWrap)
  );

  always #5 clk = ~clk;

  wire [21:0] dutVec = {volume1, volume0, minutes0, seconds1, seconds0, select, timeWrap};

  // Expected outputs derived from the model's plain-integer state.
  function automatic logic [21:0] expectedVec();
    return {4'(mVol / 10), 4'(mVol % 10), 4'(mSecs / 60), 4'((mSecs % 60) / 10),
            4'(mSecs % 10), (mLeft > 0), mWrap};
  endfunction

  // Drives one cycle of inputs, advances the model at the clock edge, and
  // returns 1 time unit after the edge so outputs can be sampled.
  task automatic applyStimulus(input bit r, input bit p, input bit rs, input bit u, input bit d);
    bit tick;
    reset = r; play = p; restart = rs; volUp = u; volDown = d;
    @(posedge clk);
    if (reset) begin
      mSecs = 0; mPre = 0; mVol = VOL_DEF; mLeft = 0; mWrap = 1'b0;
    end else begin
      tick = play && (mPre == CLK_FREQ - 1);
      mWrap = 1'b0;
      if (restart) begin
        mSecs = 0; mPre = 0;
      end else begin
        if (play) mPre = (mPre + 1) % CLK_FREQ;
        if (tick) begin
          mWrap = (mSecs == 599);
          mSecs = (mSecs + 1) % 600;
        end
      end
      if (volUp != volDown) begin
        if (volUp && mVol < VOL_TOP) mVol++;
        if (volDown && mVol > 0) mVol--;
        mLeft = WINDOW;
      end else if (mLeft > 0) begin
        mLeft--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      nChecks++;
      if (dutVec !== expectedVec())
        $display("[TB] FAIL reset_cycle%0d: got %h expected %h", i, dutVec, expectedVec());
      else nPassed++;
    end
    nChecks++;
    if ({volume1, volume0, minutes0, seconds1, seconds0, select, timeWrap} !== 22'h140000)
      $display("[TB] FAIL reset_values: got %h expected %h", dutVec, 22'h140000);
    else nPassed++;
    // Reset mid-count must also discard the prescaler progress.
    for (int i = 0; i < 23; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (seconds0 !== 4'd0) $display("[TB] FAIL reset_midcount_pre: got s0=%0d expected 0", seconds0);
    else nPassed++;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (seconds0 !== 4'd1) $display("[TB] FAIL reset_midcount_tick: got s0=%0d expected 1", seconds0);
    else nPassed++;
  endtask

  task automatic test_pause();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (seconds0 !== 4'd0) $display("[TB] FAIL pause_hold: got s0=%0d expected 0", seconds0);
    else nPassed++;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (seconds0 !== 4'd1) $display("[TB] FAIL pause_resume: got s0=%0d expected 1", seconds0);
    else nPassed++;
    nChecks++;
    if (dutVec !== expectedVec()) $display("[TB] FAIL pause_model: got %h expected %h", dutVec, expectedVec());
    else nPassed++;
  endtask

  task automatic test_restart_on_tick();
    int volBefore;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WINDOW + 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 29; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (seconds0 !== 4'd2) $display("[TB] FAIL restart_pre_time: got s0=%0d expected 2", seconds0);
    else nPassed++;
    volBefore = mVol;
    // Next edge is a tick; restart and a both-buttons press land on it.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    nChecks++;
    if ({minutes0, seconds1, seconds0, timeWrap, select} !== 14'h0)
      $display("[TB] FAIL restart_on_tick: got %h expected 0", {minutes0, seconds1, seconds0, timeWrap, select});
    else nPassed++;
    nChecks++;
    if ({volume1, volume0} !== {4'(volBefore / 10), 4'(volBefore % 10)})
      $display("[TB] FAIL both_press_volume: got %h expected %0d", {volume1, volume0}, volBefore);
    else nPassed++;
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (seconds0 !== 4'd1) $display("[TB] FAIL restart_prescaler_cleared: got s0=%0d expected 1", seconds0);
    else nPassed++;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nChecks++;
    if (dutVec !== expectedVec() || seconds0 !== 4'd0)
      $display("[TB] FAIL restart_paused: got %h expected %h", dutVec, expectedVec());
    else nPassed++;
  endtask

  task automatic test_volume_limits();
    int budget = 200;
    int selCount = 0;
    while (mVol != 10 && budget > 0) begin
      applyStimulus(1'b0, 1'b0, 1'b0, mVol < 10, mVol > 10);
      budget--;
    end
    nChecks++;
    if ({volume1, volume0} !== 8'h10) $display("[TB] FAIL vol_reach_10: got %h expected 10", {volume1, volume0});
    else nPassed++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nChecks++;
    if ({volume1, volume0} !== 8'h09) $display("[TB] FAIL vol_borrow: got %h expected 09", {volume1, volume0});
    else nPassed++;
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WINDOW + 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nChecks++;
    if ({volume1, volume0} !== 8'h00) $display("[TB] FAIL vol_floor: got %h expected 00", {volume1, volume0});
    else nPassed++;
    if (select === 1'b1) selCount++;
    for (int i = 0; i < WINDOW + 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (select === 1'b1) selCount++;
      nChecks++;
      if (dutVec !== expectedVec()) $display("[TB] FAIL floor_window_model: got %h expected %h", dutVec, expectedVec());
      else nPassed++;
    end
    nChecks++;
    if (selCount != WINDOW) $display("[TB] FAIL floor_select_len: got %0d expected %0d", selCount, WINDOW);
    else nPassed++;
  endtask

  task automatic test_volume_max();
    int budget = 200;
    int selCount = 0;
    while (mVol != VOL_TOP && budget > 0) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      budget--;
    end
    for (int i = 0; i < WINDOW + 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nChecks++;
    if ({volume1, volume0, select} !== 9'h133) $display("[TB] FAIL vol_ceiling: got %h expected 133", {volume1, volume0, select});
    else nPassed++;
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (select === 1'b1) selCount++;
    for (int i = 0; i < WINDOW + 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (select === 1'b1) selCount++;
    end
    nChecks++;
    if (selCount != WINDOW) $display("[TB] FAIL retrigger_select_len: got %0d expected %0d", selCount, WINDOW);
    else nPassed++;
  endtask

  task automatic test_wrap();
    int budget = 10000;
    int wraps = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (!(mSecs == 598 && mPre == 0) && budget > 0) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 7) != 0), 1'b0,
                    1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 63) == 0));
      budget--;
      nChecks++;
      if (dutVec !== expectedVec()) $display("[TB] FAIL runup_model: got %h expected %h", dutVec, expectedVec());
      else nPassed++;
    end
    nChecks++;
    if (budget == 0) $display("[TB] FAIL runup_budget: got budget 0 required 9:58 reached");
    else nPassed++;
    for (int i = 1; i <= 21; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (timeWrap === 1'b1) wraps++;
      if (i == 10) begin
        nChecks++;
        if ({minutes0, seconds1, seconds0} !== 12'h959)
          $display("[TB] FAIL time_959: got %h expected 959", {minutes0, seconds1, seconds0});
        else nPassed++;
      end
      if (i == 20) begin
        nChecks++;
        if ({minutes0, seconds1, seconds0, timeWrap} !== 13'h0001)
          $display("[TB] FAIL time_rollover: got %h expected 0001", {minutes0, seconds1, seconds0, timeWrap});
        else nPassed++;
      end
    end
    nChecks++;
    if (wraps != 1) $display("[TB] FAIL wrap_pulse_count: got %0d expected 1", wraps);
    else nPassed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 11) == 0));
      nChecks++;
      if (dutVec !== expectedVec()) $display("[TB] FAIL random_model: got %h expected %h", dutVec, expectedVec());
      else nPassed++;
    end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_restart_on_tick();
    test_volume_limits();
    test_volume_max();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
